// File: rtl/float_pkg.sv
// Shared constants and operand-class type for the float add stage.
package float_pkg;

   localparam int          EXP_W   = 8;
   localparam int          FRAC_W  = 23;
   localparam logic [7:0]  EXP_MAX = 8'hFF;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;

   // Operand classes the adder cannot handle on its own.
   typedef struct packed {
      logic zero;      // exponent 0 (zero or denormal, denormals flushed)
      logic special;   // exponent all-ones (Inf or NaN)
   } fp_class_t;

endpackage

// File: rtl/float_classify.sv
// Combinational classifier for one IEEE-754 single operand.
module float_classify
   import float_pkg::*;
(
   input  logic [31:0] operand,
   output fp_class_t   cls
);

   logic [EXP_W-1:0] exp_field;

   assign exp_field   = operand[FRAC_W +: EXP_W];
   assign cls.zero    = (exp_field == '0);
   assign cls.special = (exp_field == EXP_MAX);

endmodule

// File: rtl/float_add_stage.sv
// Two-stage issue/retire wrapper around an external combinational FloatAdder.
// S1 holds the operands (which drive the adder) plus their classification;
// S2 holds the selected result until the consumer takes it.
module float_add_stage
   import float_pkg::*;
#(
   parameter int TAG_W = 5,
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      add_num1,
   output logic [31:0]      add_num2,
   input  logic [31:0]      add_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_sum,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_bypass,
   output logic             out_invalid,
   output logic [CNT_W-1:0] op_count
);

   // S1 state
   logic             s1_valid_reg;
   logic [31:0]      a_reg;
   logic [31:0]      b_reg;
   logic [TAG_W-1:0] s1_tag_reg;
   fp_class_t        a_cls_reg;
   fp_class_t        b_cls_reg;
   logic             cancel_reg;

   // S2 state
   logic             s2_valid_reg;
   logic [31:0]      sum_reg;
   logic [TAG_W-1:0] s2_tag_reg;
   logic             bypass_reg;
   logic             invalid_reg;
   logic [CNT_W-1:0] count_reg;

   // Combinational helpers
   logic [31:0]      in_ops [2];
   fp_class_t        in_cls [2];
   logic             in_cancel;
   logic             s2_free;
   logic             s1_adv;
   logic             accept;
   logic             retire;
   logic [31:0]      sum_next;
   logic             bypass_next;
   logic             invalid_next;

   assign in_ops[0] = in_a;
   assign in_ops[1] = in_b;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cls
         float_classify u_classify (
            .operand (in_ops[gi]),
            .cls     (in_cls[gi])
         );
      end
   endgenerate

   // Exact cancellation only matters when both operands are ordinary normals;
   // zero and special cases are resolved by higher-priority rules.
   assign in_cancel = (in_a[30:0] == in_b[30:0]) && (in_a[31] != in_b[31]) &&
                      !in_cls[0].zero && !in_cls[0].special &&
                      !in_cls[1].zero && !in_cls[1].special;

   assign s2_free  = !s2_valid_reg || out_ready;
   assign s1_adv   = s1_valid_reg && s2_free;
   assign in_ready = !s1_valid_reg || s2_free;
   assign accept   = in_valid && in_ready;
   assign retire   = s2_valid_reg && out_ready;

   // Result select for the S1 -> S2 transfer, highest priority first.
   always_comb begin
      sum_next     = add_sum;
      bypass_next  = 1'b0;
      invalid_next = 1'b0;
      if (a_cls_reg.special || b_cls_reg.special) begin
         sum_next     = QNAN;
         bypass_next  = 1'b1;
         invalid_next = 1'b1;
      end else if (a_cls_reg.zero && b_cls_reg.zero) begin
         sum_next    = {a_reg[31] & b_reg[31], 31'b0};
         bypass_next = 1'b1;
      end else if (a_cls_reg.zero) begin
         sum_next    = b_reg;
         bypass_next = 1'b1;
      end else if (b_cls_reg.zero) begin
         sum_next    = a_reg;
         bypass_next = 1'b1;
      end else if (cancel_reg) begin
         sum_next    = 32'h0000_0000;
         bypass_next = 1'b1;
      end
   end

   // S1: load on accept, otherwise empty out when the pair moves to S2.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         a_reg        <= '0;
         b_reg        <= '0;
         s1_tag_reg   <= '0;
         a_cls_reg    <= '0;
         b_cls_reg    <= '0;
         cancel_reg   <= 1'b0;
      end else if (accept) begin
         s1_valid_reg <= 1'b1;
         a_reg        <= in_a;
         b_reg        <= in_b;
         s1_tag_reg   <= in_tag;
         a_cls_reg    <= in_cls[0];
         b_cls_reg    <= in_cls[1];
         cancel_reg   <= in_cancel;
      end else if (s1_adv) begin
         s1_valid_reg <= 1'b0;
      end
   end

   // S2: capture the selected result when S1 advances; hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_reg <= 1'b0;
         sum_reg      <= '0;
         s2_tag_reg   <= '0;
         bypass_reg   <= 1'b0;
         invalid_reg  <= 1'b0;
      end else if (s1_adv) begin
         s2_valid_reg <= 1'b1;
         sum_reg      <= sum_next;
         s2_tag_reg   <= s1_tag_reg;
         bypass_reg   <= bypass_next;
         invalid_reg  <= invalid_next;
      end else if (retire) begin
         s2_valid_reg <= 1'b0;
      end
   end

   // Retired-operation counter, wraps silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (retire) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign add_num1    = a_reg;
   assign add_num2    = b_reg;
   assign out_valid   = s2_valid_reg;
   assign out_sum     = sum_reg;
   assign out_tag     = s2_tag_reg;
   assign out_bypass  = bypass_reg;
   assign out_invalid = invalid_reg;
   assign op_count    = count_reg;

endmodule

// File: doc/float_add_stage.md
# float_add_stage

Pipelined issue/retire wrapper around the combinational FloatAdder datapath. It accepts operand pairs over a valid/ready handshake and screens special operands that the adder cannot handle (zero/denormal, Inf/NaN, exact cancellation). It registers the operands that drive the adder and captures the adder's sum into a result register with its own valid/ready handshake. The block sits between the FPU operand-fetch/decode logic and the register-file writeback of the 32-bit RISC core.

## Interface
Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside each operation
- CNT_W, 16, width of the retired-operation counter

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept a pair this cycle
- in_a  input  32  IEEE-754 single operand A
- in_b  input  32  IEEE-754 single operand B
- in_tag  input  TAG_W  destination tag
- add_num1  output  32  registered operand A, drives FloatAdder num1
- add_num2  output  32  registered operand B, drives FloatAdder num2
- add_sum  input  32  FloatAdder sum, combinational from add_num1/add_num2
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  32  result
- out_tag  output  TAG_W  tag of the result
- out_bypass  output  1  result came from special-case logic, not the adder
- out_invalid  output  1  operand was Inf/NaN
- op_count  output  CNT_W  number of retired results, wraps modulo 2^CNT_W

## Operation
- Two register stages: S1 (operand), S2 (result). Each stage has a valid bit; S1 also holds tag and class bits.
- Accept: in_valid && in_ready loads S1 with in_a, in_b, in_tag and the operand classification.
- Advance rules:
  - s2_free = !s2_valid || out_ready
  - s1 advances when s1_valid && s2_free
  - in_ready = !s1_valid || s2_free (combinational from out_ready)
- Classification, done at S1 load:
  - zero: exp == 0, with denormals treated as zero
  - special: exp == 255
  - cancel: a[30:0] == b[30:0] && a[31] != b[31] && neither operand is zero or special
- S2 result selection, in priority order:
  - any special operand: 7FC00000, bypass=1, invalid=1
  - both zero: {a[31]&b[31], 31'b0}, bypass=1
  - one zero: the other operand unchanged, bypass=1
  - cancel: 00000000, bypass=1
  - otherwise: add_sum, bypass=0
- add_num1/add_num2 always reflect the S1 registers, including when S1 is invalid.
- op_count increments by 1 on each cycle with out_valid && out_ready.
- Reset:
  - s1_valid, s2_valid = 0
  - add_num1, add_num2, out_sum, out_tag = 0
  - out_bypass, out_invalid = 0
  - op_count = 0
  - any operation in flight is discarded with no partial output
  - in_ready = 1 in the first cycle after reset

## Timing
- Latency: a pair accepted at edge k appears with out_valid=1 after edge k+1 (2 cycles, accept to present).
- Throughput: 1 operation per cycle when out_ready is held high.
- out_valid, out_sum, out_tag and flags hold stable while out_valid && !out_ready.
- Backpressure: with out_ready low, at most two operations are held (S1 and S2). in_ready drops in the cycle both are full and rises in the same cycle out_ready rises.
- Accept and retire in the same cycle are legal; no bubble is inserted.
- FloatAdder is purely combinational. The S1-to-S2 path includes its full delay.
- op_count wraps from all-ones to 0 with no flag.

## Structure
- float_pkg holds:
  - EXP_W=8, FRAC_W=23, EXP_MAX=8'hFF, QNAN=32'h7FC00000
  - a packed fp_class_t typedef {zero, special}
- One sub-module, float_classify: combinational, takes one 32-bit operand and produces fp_class_t. It is instantiated twice.
- FloatAdder is instantiated by the parent FPU, not inside this block.

## Test plan
- 3F800000 + 3F800000 with out_ready=1 -> out_sum=40000000, bypass=0, out_valid exactly 2 cycles after accept, op_count=1.
- 00000000 + 40400000 -> 40400000, bypass=1. 80000000 + 80000000 -> 80000000.
- 3FC00000 + BFC00000 -> 00000000, bypass=1. 7F800000 + 3F800000 -> 7FC00000, invalid=1.
- Back-to-back stream of 4 pairs with tags 1..4, out_ready low for cycles 2-5:
  - in_ready=0 while both stages are full
  - all 4 results delivered in tag order 1..4 with no duplicates
  - op_count=4
- rst asserted for 1 cycle with S1 and S2 both valid -> next cycle out_valid=0, op_count=0, in_ready=1, and no stale result emerges afterwards.
- 70000 consecutive retirements with CNT_W=16 -> op_count wraps to 4464 (70000 mod 65536).
